// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one outstanding text-memory request at a
// time and buffers returned instructions in a small FIFO for the ID stage.
//
// state   | meaning
// S_REQ   | presenting fetch_pc on the request bus while buffer space is free
// S_WAIT  | request accepted, next response is pushed with req_pc
// S_DISC  | request accepted before a redirect, next response is dropped
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_consume,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_available,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISC} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_inst_q [FIFO_DEPTH];
  logic [31:0]     fifo_inst_d [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_pc_d   [FIFO_DEPTH];

  logic handshake;
  logic push;
  logic pop;

  assign imem_req_valid = !reset && (state_q == S_REQ) && (count_q < CW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign inst_available = (count_q != '0);
  assign inst           = inst_available ? fifo_inst_q[rd_ptr_q] : NOP;
  assign inst_pc        = inst_available ? fifo_pc_q[rd_ptr_q] : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d    = S_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DISC: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A redirect overrides everything above: the in-flight response, if any, is dead.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      push       = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = handshake ? S_DISC : S_REQ;
        S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DISC;
        S_DISC:  state_d = imem_resp_valid ? S_REQ : S_DISC;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    pop         = inst_consume && inst_available && !redirect;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = imem_resp_data;
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_inst_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: the memory side is driven by hand,
// one cycle at a time, and every output is compared against hand-computed values.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_consume;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_available;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .inst_consume    (inst_consume),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_available  (inst_available),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset           = 1'b1;
    inst_consume    = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    step();
    step();
    chk("rst_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_avail", 32'(inst_available), 32'd0);
    chk("rst_inst",  inst,    NOP);
    chk("rst_pc",    inst_pc, 32'h0);

    // zero-wait memory: first request in cycle 0, data visible in cycle 2
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("c0_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_addr",  imem_req_addr, 32'h0040_0000);
    step();
    chk("c1_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_0001;
    step();
    imem_resp_valid = 1'b0;
    chk("c2_avail", 32'(inst_available), 32'd1);
    chk("c2_inst",  inst,    32'h1111_0001);
    chk("c2_pc",    inst_pc, 32'h0040_0000);
    chk("c2_addr",  imem_req_addr, 32'h0040_0004);
    chk("c2_valid", 32'(imem_req_valid), 32'd1);

    // fill the buffer without consuming
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2222_0002;
    step();
    imem_resp_valid = 1'b0;
    chk("full_valid", 32'(imem_req_valid), 32'd0);
    chk("full_head",  inst, 32'h1111_0001);
    step();
    chk("full_hold",  32'(imem_req_valid), 32'd0);
    imem_req_ready = 1'b0;
    inst_consume   = 1'b1;
    step();
    inst_consume = 1'b0;
    chk("pop1_inst",  inst,    32'h2222_0002);
    chk("pop1_pc",    inst_pc, 32'h0040_0004);
    chk("pop1_valid", 32'(imem_req_valid), 32'd1);
    chk("pop1_addr",  imem_req_addr, 32'h0040_0008);

    // ready low for 5 cycles: request held stable
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr",  imem_req_addr, 32'h0040_0008);
      step();
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    chk("stall_hs", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h3333_0003;
    step();
    imem_resp_valid = 1'b0;
    chk("order_head", inst, 32'h2222_0002);
    inst_consume = 1'b1;
    step();
    chk("order_inst", inst,    32'h3333_0003);
    chk("order_pc",   inst_pc, 32'h0040_0008);
    chk("order_addr", imem_req_addr, 32'h0040_000C);
    step();
    chk("empty_avail", 32'(inst_available), 32'd0);
    chk("empty_inst",  inst,    NOP);
    chk("empty_pc",    inst_pc, 32'h0);
    step();
    inst_consume = 1'b0;
    chk("underflow_avail", 32'(inst_available), 32'd0);

    // redirect while waiting, response three cycles later is dropped
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0040_0100;
    step();
    redirect = 1'b0;
    chk("disc_valid", 32'(imem_req_valid), 32'd0);
    step();
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0004;
    step();
    imem_resp_valid = 1'b0;
    chk("disc_avail", 32'(inst_available), 32'd0);
    chk("disc_valid2", 32'(imem_req_valid), 32'd1);
    chk("disc_addr",  imem_req_addr, 32'h0040_0100);

    // redirect coincident with the response, unaligned target
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0005;
    redirect        = 1'b1;
    redirect_pc     = 32'h0040_0203;
    step();
    imem_resp_valid = 1'b0;
    redirect        = 1'b0;
    chk("rsp_redir_avail", 32'(inst_available), 32'd0);
    chk("rsp_redir_valid", 32'(imem_req_valid), 32'd1);
    chk("rsp_redir_addr",  imem_req_addr, 32'h0040_0200);

    // redirect of a pending request: address moves, valid stays up
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0300;
    step();
    redirect = 1'b0;
    chk("req_redir_valid", 32'(imem_req_valid), 32'd1);
    chk("req_redir_addr",  imem_req_addr, 32'h0040_0300);

    // redirect in the handshake cycle: the accepted request is discarded
    imem_req_ready = 1'b1;
    redirect       = 1'b1;
    redirect_pc    = 32'h0040_0400;
    step();
    imem_req_ready = 1'b0;
    redirect       = 1'b0;
    chk("hs_redir_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0006;
    step();
    imem_resp_valid = 1'b0;
    chk("hs_redir_avail", 32'(inst_available), 32'd0);
    chk("hs_redir_addr",  imem_req_addr, 32'h0040_0400);

    // async reset mid-WAIT with a non-empty buffer
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h4444_0007;
    step();
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("pre_rst_inst", inst,    32'h4444_0007);
    chk("pre_rst_pc",   inst_pc, 32'h0040_0400);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_avail", 32'(inst_available), 32'd0);
    chk("arst_inst",  inst,    NOP);
    chk("arst_pc",    inst_pc, 32'h0);
    step();
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0008;
    #1;
    chk("rst2_addr",  imem_req_addr, 32'h0040_0000);
    step();
    imem_resp_valid = 1'b0;
    chk("stale_avail", 32'(inst_available), 32'd0);
    chk("stale_addr",  imem_req_addr, 32'h0040_0000);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_0009;
    step();
    imem_resp_valid = 1'b0;
    chk("rst2_avail", 32'(inst_available), 32'd1);
    chk("rst2_inst",  inst,    32'h5555_0009);
    chk("rst2_pc",    inst_pc, 32'h0040_0000);
    chk("rst2_next",  imem_req_addr, 32'h0040_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
